// File: rtl/attosoc_timer.sv
// rtl/attosoc_timer.sv - memory-mapped prescaled timer with compare match and irq
`timescale 1ns/1ps
module attosoc_timer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
  parameter logic [31:0] RESET_PRESCALE = 32'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq_out
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DONE} state_t;

  state_t      r_state;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic [2:0]  r_off;
  logic [2:0]  r_ctrl;      // bit0 EN, bit1 AUTORELOAD, bit2 IRQEN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_match;
  logic [31:0] r_prescale;
  logic [31:0] r_pcnt;

  logic        w_sel;
  logic        w_wr;
  logic        w_tick;
  logic        w_hit;
  logic [31:0] w_rd_val;
  logic        w_unused_addr;

  // Byte-lane merge of bus write data into an existing register value
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  assign w_sel         = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
  // Write commits on the edge that ends ACK, only if the request is still up
  assign w_wr          = (r_state == S_ACK) && mem_valid && (mem_wstrb != 4'b0000);
  assign w_tick        = r_ctrl[0] && (r_pcnt == r_prescale);
  assign w_hit         = w_tick && (r_count == r_compare);
  assign w_unused_addr = &{1'b0, mem_addr[1:0]};

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign irq_out   = r_match & r_ctrl[2];

  // Read mux for the register addressed by the current request
  always_comb begin
    w_rd_val = 32'd0;
    case (mem_addr[4:2])
      3'd0:    w_rd_val = {29'd0, r_ctrl};
      3'd1:    w_rd_val = r_count;
      3'd2:    w_rd_val = r_compare;
      3'd3:    w_rd_val = {31'd0, r_match};
      3'd4:    w_rd_val = r_prescale;
      default: w_rd_val = 32'd0;
    endcase
  end

  // Responder FSM: one wait state, ready for exactly one cycle per request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
      r_off   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel) begin
            r_state <= S_ACK;
            r_ready <= 1'b1;
            r_rdata <= w_rd_val;
            r_off   <= mem_addr[4:2];
          end
        end
        S_ACK: begin
          r_state <= S_DONE;
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
        end
        S_DONE: begin
          if (!mem_valid) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
        end
      endcase
    end
  end

  // Timer core and register writes; bus writes override tick updates,
  // while a new match overrides a same-cycle clear of MATCH
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ctrl     <= 3'd0;
      r_count    <= 32'd0;
      r_compare  <= 32'hFFFF_FFFF;
      r_match    <= 1'b0;
      r_prescale <= RESET_PRESCALE;
      r_pcnt     <= 32'd0;
    end else begin
      if (w_wr && r_off == 3'd4)    r_pcnt <= 32'd0;
      else if (!r_ctrl[0] || w_tick) r_pcnt <= 32'd0;
      else                           r_pcnt <= r_pcnt + 32'd1;

      if (w_wr && r_off == 3'd1)
        r_count <= f_merge(r_count, mem_wdata, mem_wstrb);
      else if (w_tick)
        r_count <= (w_hit && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;

      if (w_hit)
        r_match <= 1'b1;
      else if (w_wr && r_off == 3'd3 && mem_wstrb[0] && mem_wdata[0])
        r_match <= 1'b0;

      if (w_wr && r_off == 3'd0 && mem_wstrb[0]) r_ctrl <= mem_wdata[2:0];
      if (w_wr && r_off == 3'd2) r_compare  <= f_merge(r_compare, mem_wdata, mem_wstrb);
      if (w_wr && r_off == 3'd4) r_prescale <= f_merge(r_prescale, mem_wdata, mem_wstrb);
    end
  end

endmodule

// File: tb/tb_attosoc_timer.sv
// tb/tb_attosoc_timer.sv - self-checking bench for attosoc_timer
`timescale 1ns/1ps
module tb_attosoc_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq_out;

  int checks = 0;
  int errors = 0;

  attosoc_timer #(.BASE_ADDR(BASE), .RESET_PRESCALE(32'd0)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .irq_out(irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register file as seen by software plus prescaler count
  logic [31:0] m_reg [0:7];   // 0 CTRL,1 COUNT,2 COMPARE,3 STATUS,4 PRESCALE
  logic [31:0] m_pcnt;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
    m_reg[2] = 32'hFFFF_FFFF;
    m_pcnt   = 32'd0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] off);
    return (off <= 3'd4) ? m_reg[off] : 32'd0;
  endfunction

  function automatic logic model_irq();
    return m_reg[3][0] && m_reg[0][2];
  endfunction

  function automatic void model_step(input bit we, input logic [2:0] off,
                                     input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] mask;
    logic [31:0] merged;
    bit tick, hit;
    mask   = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    merged = (off <= 3'd4) ? ((m_reg[off] & ~mask) | (wd & mask)) : 32'd0;
    tick   = m_reg[0][0] && (m_pcnt == m_reg[4]);
    hit    = tick && (m_reg[1] == m_reg[2]);
    if (m_reg[0][0] == 1'b0 || tick) m_pcnt = 0; else m_pcnt = m_pcnt + 1;
    if (tick) m_reg[1] = (hit && m_reg[0][1]) ? 32'd0 : m_reg[1] + 32'd1;
    if (we) begin
      case (off)
        3'd0: m_reg[0] = merged & 32'd7;
        3'd1: m_reg[1] = merged;
        3'd2: m_reg[2] = merged;
        3'd3: if (st[0] && wd[0]) m_reg[3] = 32'd0;
        3'd4: begin m_reg[4] = merged; m_pcnt = 0; end
        default: ;
      endcase
    end
    if (hit) m_reg[3] = 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk_edge(input bit we, input logic [2:0] off,
                          input logic [31:0] wd, input logic [3:0] st);
    @(posedge clk);
    model_step(we, off, wd, st);
    #1;
    chk("irq", {31'd0, irq_out}, {31'd0, model_irq()});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_edge(1'b0, 3'd0, 32'd0, 4'd0);
  endtask

  task automatic xfer(input logic [2:0] off, input logic [31:0] wd,
                      input logic [3:0] st, input bit abort,
                      output logic [31:0] rd);
    logic [31:0] exp;
    mem_addr  = BASE + {27'd0, off, 2'b00};
    mem_wdata = wd;
    mem_wstrb = st;
    mem_valid = 1'b1;
    chk("ready_wait", {31'd0, mem_ready}, 32'd0);
    exp = model_read(off);
    clk_edge(1'b0, off, wd, st);
    chk("ready_ack", {31'd0, mem_ready}, 32'd1);
    chk("rdata", mem_rdata, exp);
    rd = mem_rdata;
    if (abort) mem_valid = 1'b0;
    clk_edge(!abort && st != 4'd0, off, wd, st);
    chk("ready_done", {31'd0, mem_ready}, 32'd0);
    chk("rdata_done", mem_rdata, 32'd0);
    mem_valid = 1'b0;
    clk_edge(1'b0, off, wd, st);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] wd);
    logic [31:0] d;
    xfer(off, wd, 4'hF, 1'b0, d);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] v);
    xfer(off, 32'd0, 4'h0, 1'b0, v);
  endtask

  initial begin
    logic [31:0] v;
    logic [2:0]  off;
    logic [31:0] wd;
    logic [3:0]  st;
    bit          ab;

    resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_irq", {31'd0, irq_out}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    idle(2);

    // reset values through the bus
    for (int i = 0; i < 8; i++) rd(i[2:0], v);

    // read handshake with mem_valid held past the acknowledge
    mem_addr = BASE + 32'd8; mem_wstrb = 4'd0; mem_wdata = 32'd0; mem_valid = 1'b1;
    chk("hs_c1", {31'd0, mem_ready}, 32'd0);
    clk_edge(1'b0, 3'd0, 32'd0, 4'd0);
    chk("hs_c2", {31'd0, mem_ready}, 32'd1);
    chk("hs_data", mem_rdata, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      clk_edge(1'b0, 3'd0, 32'd0, 4'd0);
      chk("hs_hold", {31'd0, mem_ready}, 32'd0);
    end
    mem_valid = 1'b0;
    clk_edge(1'b0, 3'd0, 32'd0, 4'd0);

    // byte-lane write
    xfer(3'd2, 32'hAABB_CCDD, 4'b0010, 1'b0, v);
    rd(3'd2, v);
    chk("byte_wr", v, 32'hFFFF_CCFF);

    // unselected address: no acknowledge
    mem_addr = BASE + 32'd32; mem_valid = 1'b1;
    idle(1);
    chk("unsel", {31'd0, mem_ready}, 32'd0);
    mem_valid = 1'b0;
    idle(1);

    // match and irq with autoreload
    wr(3'd4, 32'd1);
    wr(3'd2, 32'd3);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd7);
    for (int i = 0; i < 6; i++) begin rd(3'd1, v); rd(3'd3, v); end
    wr(3'd3, 32'd1);
    chk("w1c_irq", {31'd0, irq_out}, {31'd0, model_irq()});
    rd(3'd3, v);

    // 32-bit wrap without autoreload
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd0);
    wr(3'd1, 32'hFFFF_FFFE);
    wr(3'd2, 32'd5);
    wr(3'd3, 32'd1);
    wr(3'd0, 32'd1);
    for (int i = 0; i < 4; i++) begin rd(3'd1, v); rd(3'd3, v); end

    // collisions: COUNT write with tick, W1C with a new match
    wr(3'd0, 32'd0);
    wr(3'd3, 32'd1);
    wr(3'd2, 32'd102);
    wr(3'd0, 32'd1);
    wr(3'd1, 32'd100);
    wr(3'd3, 32'd1);
    rd(3'd3, v);
    chk("w1c_set_wins", v, 32'd1);
    rd(3'd1, v);

    // reset in ACK with a CTRL write pending, then mem_valid kept high
    mem_addr = BASE; mem_wdata = 32'd7; mem_wstrb = 4'hF; mem_valid = 1'b1;
    clk_edge(1'b0, 3'd0, 32'd0, 4'd0);
    chk("pre_rst_ack", {31'd0, mem_ready}, 32'd1);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_ack_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_ack_rdata", mem_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_wstrb = 4'd0;
    resetn = 1'b1;
    clk_edge(1'b0, 3'd0, 32'd0, 4'd0);
    chk("post_rst_ack", {31'd0, mem_ready}, 32'd1);
    chk("post_rst_ctrl", mem_rdata, 32'd0);
    mem_valid = 1'b0;
    idle(2);

    // unmapped offset 7
    xfer(3'd7, 32'h1234_5678, 4'hF, 1'b0, v);
    rd(3'd7, v);
    chk("off7", v, 32'd0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      off = 3'($urandom_range(0, 7));
      case (off)
        3'd0:    wd = $urandom_range(0, 7);
        3'd1:    wd = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 20);
        3'd2:    wd = $urandom_range(0, 20);
        3'd4:    wd = $urandom_range(0, 3);
        default: wd = $urandom;
      endcase
      st = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      ab = ($urandom_range(0, 7) == 0);
      xfer(off, wd, st, ab, v);
      idle($urandom_range(0, 3));
    end
    for (int i = 0; i < 5; i++) rd(i[2:0], v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/attosoc_timer.md
ATTOSOC_TIMER -- requirements
Module: attosoc_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0000, meaning the 32-bit base address of a 32-byte register window.
REQ-002 SHALL have parameter RESET_PRESCALE, default 32'd0, meaning the reset value of the PRESCALE register.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 mem_valid  input  1  transaction request from the CPU native memory bus.
REQ-006 mem_addr  input  32  byte address.
REQ-007 mem_wdata  input  32  write data.
REQ-008 mem_wstrb  input  4  byte write strobes; 4'b0000 means read.
REQ-009 mem_ready  output  1  transaction acknowledge.
REQ-010 mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-011 irq_out  output  1  level interrupt to the CPU irq vector.

Function
REQ-012 Select SHALL be mem_valid && mem_addr[31:5]==BASE_ADDR[31:5]; offset = mem_addr[4:2].
REQ-013 Registers: 0 CTRL (bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, others read 0); 1 COUNT; 2 COMPARE; 3 STATUS (bit0 MATCH, write-1-to-clear); 4 PRESCALE; offsets 5-7 SHALL read 0 and ignore writes, but still be acknowledged.
REQ-014 Responder FSM SHALL have states IDLE, ACK, DONE: IDLE->ACK when selected; ACK->DONE unconditionally; DONE->IDLE when mem_valid=0, else stay in DONE.
REQ-015 mem_ready SHALL be 1 only in ACK, giving exactly one wait state (ready on the second cycle of a selected mem_valid).
REQ-016 mem_rdata SHALL be registered on the IDLE->ACK transition from the selected register, and SHALL be 0 outside ACK.
REQ-017 Writes SHALL commit at the clock edge ending ACK, per byte lane under mem_wstrb; no write effect in IDLE or DONE.
REQ-018 If mem_valid drops while in ACK, the FSM SHALL go to DONE without committing the write.
REQ-019 Prescaler: internal 32-bit pcnt; when EN=1, pcnt==PRESCALE produces a tick and pcnt<=0, otherwise pcnt<=pcnt+1; when EN=0, pcnt<=0 and no ticks.
REQ-020 On tick: if COUNT==COMPARE, MATCH<=1 and COUNT<=(AUTORELOAD ? 0 : COUNT+1); otherwise COUNT<=COUNT+1, wrapping modulo 2^32 (32'hFFFF_FFFF -> 0).
REQ-021 A bus write to COUNT in the same cycle as a tick SHALL win; the match comparison in that cycle SHALL still use the pre-write COUNT.
REQ-022 A W1C of MATCH in the same cycle as a new match SHALL leave MATCH=1 (set wins).
REQ-023 A write to PRESCALE SHALL also clear pcnt to 0.
REQ-024 irq_out SHALL equal MATCH && IRQEN, driven only from registers (no combinational path from bus inputs).
REQ-025 A read of STATUS SHALL return the MATCH value as it was before any same-transaction write.

Reset
REQ-026 While resetn=0, SHALL hold: FSM=IDLE, mem_ready=0, mem_rdata=0, irq_out=0, CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, MATCH=0, PRESCALE=RESET_PRESCALE, pcnt=0.
REQ-027 Reset asserted mid-transaction SHALL abort it immediately with no register write; after release, the FSM SHALL start in IDLE and a still-asserted mem_valid SHALL be treated as a new request.

Verification
REQ-028 Read handshake: mem_valid=1, addr=BASE+8, wstrb=0 after reset -> mem_ready=1 on cycle 2 only, mem_rdata=32'hFFFF_FFFF; mem_valid held 3 more cycles -> no second ready.
REQ-029 Byte write: write 32'hAABBCCDD to BASE+8 with wstrb=4'b0010 after reset -> COMPARE reads 32'hFFFF_CCFF.
REQ-030 Match/IRQ: PRESCALE=1, COMPARE=3, CTRL=3'b111 -> COUNT advances every 2 cycles; MATCH and irq_out rise on the tick where COUNT==3, COUNT returns to 0; W1C of STATUS bit0 -> irq_out=0.
REQ-031 Wrap: CTRL=1 (no autoreload), PRESCALE=0, COUNT=32'hFFFF_FFFE, COMPARE=5 -> COUNT reaches 32'hFFFF_FFFF, then 0, then MATCH=1 when COUNT==5 and COUNT continues to 6.
REQ-032 Collisions: a COUNT write of 100 coinciding with a tick -> COUNT=100; a W1C coinciding with a match -> MATCH stays 1.
REQ-033 Reset mid-ACK with a write pending to CTRL -> CTRL=0 and mem_ready=0 immediately; unmapped offset 7 read -> 0 with a normal single-cycle ready.
